// File: rtl/key_pkg.sv
// Shared types, defaults and counter sizing for the pushbutton conditioner.
package key_pkg;

   typedef enum logic [1:0] {UP, PEND_DN, DOWN, PEND_UP} key_state_t;

   localparam int DEF_NUM_KEYS        = 4;
   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_REPEAT_DELAY    = 8;
   localparam int DEF_REPEAT_RATE     = 3;

   // One counter width serves both the debounce and the repeat timers.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce FSM, optional hold-to-repeat.
// Hold-to-repeat is built only when KEY_AUTOREPEAT_EN is defined.
//
// state   | meaning
// UP      | key released and stable
// PEND_DN | press seen, counting stable cycles
// DOWN    | key pressed and stable
// PEND_UP | release seen, counting stable cycles
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic key_n_i,
   output logic level_o,
   output logic press_o,
   output logic release_o
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [1:0]      sync_q;
   key_state_t      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            level_q, level_d;
   logic            press_q, press_d;
   logic            release_q, release_d;
   logic            pressed;
   logic            enter_down;

   assign pressed = ~sync_q[1];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q    <= 2'b11;
         state_q   <= UP;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], key_n_i};
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

`ifdef KEY_AUTOREPEAT_EN
   localparam logic [CW-1:0] RPT_DELAY = CW'(REPEAT_DELAY);
   localparam logic [CW-1:0] RPT_RATE  = CW'(REPEAT_RATE);

   // Down-counter to the next repeat; zero means repeats are idle.
   logic [CW-1:0] rpt_q, rpt_d;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) rpt_q <= '0;
      else          rpt_q <= rpt_d;
   end
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      level_d    = level_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      enter_down = 1'b0;
      case (state_q)
         UP: begin
            if (pressed) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d    = DOWN;
                  level_d    = 1'b1;
                  press_d    = 1'b1;
                  enter_down = 1'b1;
               end else begin
                  state_d = PEND_DN;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         PEND_DN: begin
            if (!pressed) begin
               state_d = UP;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d    = DOWN;
               cnt_d      = '0;
               level_d    = 1'b1;
               press_d    = 1'b1;
               enter_down = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         DOWN: begin
            if (!pressed) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d   = UP;
                  level_d   = 1'b0;
                  release_d = 1'b1;
               end else begin
                  state_d = PEND_UP;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         PEND_UP: begin
            if (pressed) begin
               state_d = DOWN;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d   = UP;
               cnt_d     = '0;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = UP;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
`ifdef KEY_AUTOREPEAT_EN
      // A bounce back into DOWN from PEND_UP finds rpt_q cleared, so no repeats resume.
      rpt_d = rpt_q;
      if (enter_down) begin
         rpt_d = RPT_DELAY;
      end else if (state_q != DOWN || !pressed) begin
         rpt_d = '0;
      end else if (rpt_q == CNT_ONE) begin
         rpt_d   = RPT_RATE;
         press_d = 1'b1;
      end else if (rpt_q != '0) begin
         rpt_d = rpt_q - CNT_ONE;
      end
`endif
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions active-low pushbuttons into debounced levels and press/release pulses.
// Define KEY_AUTOREPEAT_EN to add hold-to-repeat press pulses.
module key_conditioner
   import key_pkg::*;
#(
   parameter int NUM_KEYS        = DEF_NUM_KEYS,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
   input  logic                Clock_i,
   input  logic                Resetn_i,
   input  logic [NUM_KEYS-1:0] KEY_n_i,
   output logic [NUM_KEYS-1:0] level_o,
   output logic [NUM_KEYS-1:0] press_o,
   output logic [NUM_KEYS-1:0] release_o
);

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_RATE     (REPEAT_RATE)
      ) u_ch (
         .clk_i     (Clock_i),
         .rst_n_i   (Resetn_i),
         .key_n_i   (KEY_n_i[g]),
         .level_o   (level_o[g]),
         .press_o   (press_o[g]),
         .release_o (release_o[g])
      );
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner; also covers KEY_AUTOREPEAT_EN builds.
module tb_key_conditioner;

   localparam int NK  = 4;
   localparam int DB  = 4;
   localparam int RD  = 8;
   localparam int RR  = 3;
   localparam int LAT = 2 + DB;

   logic          Clock  = 1'b0;
   logic          Resetn = 1'b1;
   logic [NK-1:0] KEY_n  = '1;
   logic [NK-1:0] level, press, rel;

   int            cyc    = 0;
   int            checks = 0;
   int            errors = 0;
   bit            mon_en = 1'b0;
   string         phase  = "init";
   logic [NK-1:0] exp_level = '0;
   logic [NK-1:0] exp_press, exp_rel;

   typedef struct {
      int            cyc;
      logic [NK-1:0] pr;
      logic [NK-1:0] rl;
      logic [NK-1:0] st;
      logic [NK-1:0] cl;
   } ev_t;

   ev_t sbq[$];
   ev_t ev_cur;

   key_conditioner #(
      .NUM_KEYS        (NK),
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_RATE     (RR)
   ) dut (
      .Clock_i   (Clock),
      .Resetn_i  (Resetn),
      .KEY_n_i   (KEY_n),
      .level_o   (level),
      .press_o   (press),
      .release_o (rel)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic push_ev(input int c, input logic [NK-1:0] pr, input logic [NK-1:0] rl,
                          input logic [NK-1:0] st, input logic [NK-1:0] cl);
      ev_t e;
      int  i;
      i = 0;
      while (i < sbq.size() && sbq[i].cyc < c) i++;
      if (i < sbq.size() && sbq[i].cyc == c) begin
         e = sbq[i];
         e.pr |= pr;
         e.rl |= rl;
         e.st |= st;
         e.cl |= cl;
         sbq[i] = e;
      end else begin
         e.cyc = c;
         e.pr  = pr;
         e.rl  = rl;
         e.st  = st;
         e.cl  = cl;
         sbq.insert(i, e);
      end
   endtask

   // Raw press becomes stable at c0, raw release at c1.
   task automatic sched_hold(input logic [NK-1:0] mask, input int c0, input int c1);
      push_ev(c0 + LAT, mask, '0, mask, '0);
`ifdef KEY_AUTOREPEAT_EN
      for (int r = c0 + LAT + RD; r <= c1 + 2; r += RR) push_ev(r, mask, '0, '0, '0);
`endif
      push_ev(c1 + LAT, '0, mask, '0, mask);
   endtask

   task automatic to_cyc(input int t);
      while (cyc < t) begin
         @(posedge Clock);
         #1;
      end
   endtask

   always @(negedge Clock) begin
      if (mon_en) begin
         exp_press = '0;
         exp_rel   = '0;
         if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            ev_cur    = sbq.pop_front();
            exp_press = ev_cur.pr;
            exp_rel   = ev_cur.rl;
            exp_level = (exp_level | ev_cur.st) & ~ev_cur.cl;
         end
         chk(phase, {20'h0, level, press, rel}, {20'h0, exp_level, exp_press, exp_rel});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cyc %0d expected < 2000", cyc);
      $fatal(1);
   end

   initial begin
      int c;
      // Keys held through reset deassertion
      #2;
      Resetn = 1'b0;
      KEY_n  = '0;
      #1;
      chk("t1_async_rst", {20'h0, level, press, rel}, 32'h0);
      repeat (3) begin
         @(posedge Clock);
         #1;
         chk("t1_in_rst", {20'h0, level, press, rel}, 32'h0);
      end
      c      = cyc;
      Resetn = 1'b1;
      phase  = "t1_held_rst";
      sched_hold('1, c, c + 15);
      mon_en = 1'b1;
      to_cyc(c + 15);
      KEY_n = '1;
      to_cyc(c + 15 + LAT + 4);

      // Clean press and release on key 0
      phase = "t2_clean";
      c = cyc;
      KEY_n[0] = 1'b0;
      sched_hold(4'b0001, c, c + 20);
      to_cyc(c + 20);
      KEY_n[0] = 1'b1;
      to_cyc(c + 20 + LAT + 4);

      // Short glitch on key 1 is rejected
      phase = "t3_glitch";
      c = cyc;
      KEY_n[1] = 1'b0;
      to_cyc(c + 3);
      KEY_n[1] = 1'b1;
      to_cyc(c + 14);

      // Bouncing key 2, settles low at c+8
      phase = "t4_bounce";
      c = cyc;
      sched_hold(4'b0100, c + 8, c + 24);
      for (int k = 0; k < 5; k++) begin
         to_cyc(c + 2 * k);
         KEY_n[2] = (k % 2 == 1);
      end
      to_cyc(c + 24);
      KEY_n[2] = 1'b1;
      to_cyc(c + 24 + LAT + 4);

      // Long hold on key 3 (repeats when enabled)
      phase = "t5_hold";
      c = cyc;
      KEY_n[3] = 1'b0;
      sched_hold(4'b1000, c, c + 30);
      to_cyc(c + 30);
      KEY_n[3] = 1'b1;
      to_cyc(c + 30 + LAT + 4);

      // Reset mid-press on key 0, key still held afterwards
      phase = "t6_mid_rst";
      c = cyc;
      KEY_n[0] = 1'b0;
      push_ev(c + LAT, 4'b0001, '0, 4'b0001, '0);
      to_cyc(c + LAT + 2);
      #2;
      mon_en = 1'b0;
      chk("t6_sb_empty", sbq.size(), 0);
      chk("t6_level_pre", {28'h0, level}, 32'h1);
      Resetn = 1'b0;
      #1;
      chk("t6_async_rst", {20'h0, level, press, rel}, 32'h0);
      exp_level = '0;
      repeat (2) begin
         @(posedge Clock);
         #1;
         chk("t6_in_rst", {20'h0, level, press, rel}, 32'h0);
      end
      c      = cyc;
      Resetn = 1'b1;
      phase  = "t6_after_rst";
      sched_hold(4'b0001, c, c + 12);
      mon_en = 1'b1;
      to_cyc(c + 12);
      KEY_n[0] = 1'b1;
      to_cyc(c + 12 + LAT + 4);

      mon_en = 1'b0;
      chk("sb_drained", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
